avalon_mem_responder: RTL
=========================

Name: avalon_mem_responder

Overview:
Avalon-MM slave (responder) holding one 16-bit word-addressed memory region. It serves the layer compute engines, which are read_n/write_n masters: image buffer, weights, and layer outputs.
- Read latency is fixed and pipelined, with optional wait states and a bounded number of outstanding reads.
- Used as the on-chip image/weight store and as the bench model for the layer engines.
- Provides sticky error reporting and a hex-LED status word.

Parameters:
BASE_ADDR, 32'd600_000, byte address of word 0 of the window.
DEPTH, 1024, number of 16-bit words; window = [BASE_ADDR, BASE_ADDR+2*DEPTH).
READ_LATENCY, 2, cycles from read acceptance to readdatavalid (1..8).
WAIT_STATES, 0, waitrequest cycles inserted before each request is accepted (0..15).
MAX_PENDING, 4, maximum reads in flight (1..8).
INIT_FILE, "", $readmemh image loaded at elaboration if non-empty.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
chipselect  in  1  slave select
read_n  in  1  active-low read request
write_n  in  1  active-low write request
byteenable  in  2  byte lanes for writes ([1]=15:8, [0]=7:0)
address  in  32  byte address; bit 0 ignored
writedata  in  16  write data
waitrequest  out  1  high = request not accepted this cycle
readdatavalid  out  1  one-cycle pulse per completed read
readdata  out  16  read data, valid with readdatavalid
err  out  1  sticky protocol/decode error
toHexLed  out  32  {rd_count[11:0], wr_count[11:0], 2'b0, err, pending[2:0], state[1:0]}

Behaviour:
- One clock. Reset is synchronous and active-high.
- Reset values: waitrequest=1 while reset is high, readdatavalid=0, readdata=0, err=0, counters=0, state=IDLE, read pipe flushed.
- Memory contents are not cleared by reset.
- Reset mid-operation: all in-flight reads are dropped, and no readdatavalid appears after reset deasserts.
- Request: req = chipselect & (~read_n | ~write_n).
- Accept: req & ~waitrequest on a rising edge.
- The master holds address, data and controls stable while waitrequest=1.
- Both read_n and write_n low: the write executes, the read is ignored, err is set.
- Decode: hit = (address >= BASE_ADDR) && (address < BASE_ADDR + 2*DEPTH); word index = (address - BASE_ADDR) >> 1.
- block = (pending == MAX_PENDING) & ~read_n. Writes are never blocked by pending reads.
- FSM states: IDLE, STALL, ACCEPT.
- IDLE, req & ~block:
  - WAIT_STATES=0: waitrequest=0 combinationally and the request is accepted this cycle; stay in IDLE.
  - Otherwise: waitrequest=1, load ws_cnt=WAIT_STATES-1, go to STALL.
- IDLE, no req or block: waitrequest=1.
- STALL: waitrequest=1. Decrement ws_cnt; at 0 go to ACCEPT. If req drops, go to IDLE with no action.
- ACCEPT: waitrequest=~(req & ~block). On acceptance go to IDLE. If req drops, go to IDLE. If blocked, hold ACCEPT.
- Write accepted in cycle N:
  - Byte lanes with byteenable set are updated at edge N.
  - A read accepted in N+1 sees the new data.
  - Out-of-window write: dropped, err set.
- Read accepted in cycle N:
  - Memory is sampled at edge N, before a simultaneous-cycle write takes effect.
  - readdatavalid=1 and readdata=word during cycle N+READ_LATENCY.
  - Out-of-window read: returns 16'hDEAD with readdatavalid on schedule, err set.
- Responses are strictly in order, with back-to-back acceptance every cycle.
- pending: +1 on read accept, -1 on readdatavalid; both in the same cycle leaves it unchanged.
- readdata holds its last value when readdatavalid=0.
- rd_count / wr_count count accepted reads/writes and wrap at 2^12.
- err clears only on reset.

Decomposition:
- Shared package: Avalon width constants (ADDR_W=32, DATA_W=16), region base constants (W1_BASE=800, LAYER1_BASE=400_000, IMG_BASE=600_000), FSM state encodings, ERR_DATA=16'hDEAD.
- One natural sub-module, rd_latency_pipe: a valid+data shift register, depth READ_LATENCY, with flush on reset.

Test Plan:
- Write 0x1234 to 600_000, then read 600_000 (defaults) -> waitrequest=0 on both; readdatavalid exactly 2 cycles after read accept with readdata=0x1234.
- Word 600_002 = 0xAAAA; write 0x55FF with byteenable=2'b01 -> a following read returns 0xAAFF.
- WAIT_STATES=3, single read -> waitrequest high for 3 cycles, accept on the 4th; readdatavalid 2 cycles later.
- MAX_PENDING=2, READ_LATENCY=4, 5 back-to-back reads -> waitrequest asserts on the 3rd read until the first readdatavalid; 5 in-order responses; pending returns to 0.
- Read 599_998 and write 602_048 (out of window) -> read returns 0xDEAD, write leaves memory unchanged, err=1 and stays set.
- 3 reads accepted, then reset pulsed 1 cycle -> no readdatavalid afterwards, pending=0, err=0, prior memory contents readable.

Source files
------------

// File: rtl/avalon_mem_responder_pkg.sv
// avalon_mem_responder shared definitions
// Bus widths, region bases, FSM encoding.
package avalon_mem_responder_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 16;

  localparam logic [ADDR_W-1:0] W1_BASE     = 32'd800;
  localparam logic [ADDR_W-1:0] LAYER1_BASE = 32'd400_000;
  localparam logic [ADDR_W-1:0] IMG_BASE    = 32'd600_000;

  localparam logic [DATA_W-1:0] ERR_DATA = 16'hDEAD;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STALL  = 2'd1,
    ST_ACCEPT = 2'd2
  } state_t;

endpackage

// File: rtl/avalon_mem_responder_if.sv
// avalon_mem_responder bus interface
// Avalon-MM signals seen by a read_n/write_n master.
interface avalon_mem_responder_if;
  import avalon_mem_responder_pkg::*;

  logic              chipselect;
  logic              read_n;
  logic              write_n;
  logic [1:0]        byteenable;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] writedata;
  logic              waitrequest;
  logic              readdatavalid;
  logic [DATA_W-1:0] readdata;

  modport master (
    output chipselect, read_n, write_n,
    output byteenable, address, writedata,
    input  waitrequest, readdatavalid, readdata
  );

  modport slave (
    input  chipselect, read_n, write_n,
    input  byteenable, address, writedata,
    output waitrequest, readdatavalid, readdata
  );

endinterface

// File: rtl/avalon_mem_responder_rd_latency_pipe.sv
// Fixed-latency read return pipe
// Each stage keeps its last data so the output holds between pulses.
module rd_latency_pipe
  import avalon_mem_responder_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data
);

  logic [LATENCY-1:0] r_vld;
  logic [DATA_W-1:0]  r_dat [LATENCY];

  // shift valid every cycle, move data only with its valid
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld <= '0;
      for (int i = 0; i < LATENCY; i++)
        r_dat[i] <= '0;
    end else begin
      r_vld[0] <= i_valid;
      if (i_valid)
        r_dat[0] <= i_data;
      for (int i = 1; i < LATENCY; i++) begin
        r_vld[i] <= r_vld[i-1];
        if (r_vld[i-1])
          r_dat[i] <= r_dat[i-1];
      end
    end
  end

  assign o_valid = r_vld[LATENCY-1];
  assign o_data  = r_dat[LATENCY-1];

endmodule

// File: rtl/avalon_mem_responder.sv
// Avalon-MM word memory responder
// Wait-state FSM, bounded pipelined reads, sticky error, status word.
module avalon_mem_responder
  import avalon_mem_responder_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR = IMG_BASE,
  parameter int    DEPTH        = 1024,
  parameter int    READ_LATENCY = 2,
  parameter int    WAIT_STATES  = 0,
  parameter int    MAX_PENDING  = 4,
  parameter string INIT_FILE    = ""
) (
  input  logic                  clk,
  input  logic                  reset,
  avalon_mem_responder_if.slave bus,
  output logic                  err,
  output logic [31:0]           toHexLed
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [ADDR_W:0] LO = {1'b0, BASE_ADDR};
  localparam logic [ADDR_W:0] HI = LO + 33'(2 * DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];

  state_t      r_state;
  logic [3:0]  r_ws;
  logic [3:0]  r_pend;
  logic [11:0] r_rdc;
  logic [11:0] r_wrc;
  logic        r_err;

  logic              w_rd;
  logic              w_wr;
  logic              w_req;
  logic              w_block;
  logic              w_hit;
  logic              w_ready;
  logic              w_acc;
  logic              w_rd_acc;
  logic              w_wr_acc;
  logic [AW-1:0]     w_idx;
  logic [DATA_W-1:0] w_rdata;
  logic              w_pv;
  logic [DATA_W-1:0] w_pd;

  assign w_rd    = ~bus.read_n;
  assign w_wr    = ~bus.write_n;
  assign w_req   = bus.chipselect & (w_rd | w_wr);
  assign w_block = (r_pend == 4'(MAX_PENDING)) & w_rd;
  assign w_hit   = ({1'b0, bus.address} >= LO) &&
                   ({1'b0, bus.address} < HI);
  assign w_idx   = AW'((bus.address - BASE_ADDR) >> 1);
  assign w_rdata = w_hit ? r_mem[w_idx] : ERR_DATA;

  // ready is only offered from IDLE (no wait states) or ACCEPT
  always_comb begin
    w_ready = 1'b0;
    if (!reset) begin
      unique case (r_state)
        ST_IDLE:   w_ready = (WAIT_STATES == 0) && w_req && !w_block;
        ST_ACCEPT: w_ready = w_req && !w_block;
        default:   w_ready = 1'b0;
      endcase
    end
  end

  assign w_acc    = w_ready & w_req;
  assign w_wr_acc = w_acc & w_wr;
  assign w_rd_acc = w_acc & w_rd & ~w_wr;

  // wait-state sequencing
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_ws    <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_req && !w_block && WAIT_STATES != 0) begin
            r_ws    <= 4'(WAIT_STATES - 1);
            r_state <= (WAIT_STATES == 1) ? ST_ACCEPT : ST_STALL;
          end
        end
        ST_STALL: begin
          if (!w_req) begin
            r_state <= ST_IDLE;
          end else begin
            r_ws <= r_ws - 4'd1;
            if (r_ws == 4'd1)
              r_state <= ST_ACCEPT;
          end
        end
        ST_ACCEPT: begin
          if (!w_req || w_ready)
            r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // byte-lane writes; contents survive reset
  always_ff @(posedge clk) begin
    if (w_wr_acc && w_hit) begin
      if (bus.byteenable[0])
        r_mem[w_idx][7:0] <= bus.writedata[7:0];
      if (bus.byteenable[1])
        r_mem[w_idx][15:8] <= bus.writedata[15:8];
    end
  end

  // counters, pending reads and sticky error
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdc  <= '0;
      r_wrc  <= '0;
      r_pend <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_rd_acc)
        r_rdc <= r_rdc + 12'd1;
      if (w_wr_acc)
        r_wrc <= r_wrc + 12'd1;
      r_pend <= r_pend + 4'(w_rd_acc) - 4'(w_pv);
      if ((w_acc && w_rd && w_wr) ||
          ((w_rd_acc || w_wr_acc) && !w_hit))
        r_err <= 1'b1;
    end
  end

  rd_latency_pipe #(
    .LATENCY (READ_LATENCY)
  ) u_pipe (
    .clk     (clk),
    .reset   (reset),
    .i_valid (w_rd_acc),
    .i_data  (w_rdata),
    .o_valid (w_pv),
    .o_data  (w_pd)
  );

  assign bus.waitrequest   = ~w_ready;
  assign bus.readdatavalid = w_pv & ~reset;
  assign bus.readdata      = w_pd;
  assign err               = r_err;
  assign toHexLed = {r_rdc, r_wrc, 2'b00, r_err, r_pend[2:0], r_state};

endmodule
